// File: rtl/restoring_divider_8x4.sv
// rtl/restoring_divider_8x4.sv - sequential 8/4 unsigned restoring divider, one step per clock
// Optional build macro DIVIDER_ZERO_SHORTCUT_EN: a zero divisor completes after one cycle instead of eight.
module restoring_divider_8x4 (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] dividend,
  input  logic [3:0] divisor,
  output logic       busy,
  output logic       done,
  output logic [7:0] quotient,
  output logic [3:0] remainder,
  output logic       div_by_zero
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t     state, state_n;
  logic [3:0] d;
  logic [3:0] r;
  logic [3:0] r_step;
  logic [7:0] a;
  logic [7:0] a_step;
  logic [2:0] cnt;
  logic [4:0] t;
  logic       qbit;
  logic       last;

  always_comb begin
    t      = {r, a[7]};
    qbit   = (t >= {1'b0, d});
    // When t >= d the difference fits in 4 bits, so the low nibble is exact.
    r_step = qbit ? (t[3:0] - d) : t[3:0];
    a_step = {a[6:0], qbit};
`ifdef DIVIDER_ZERO_SHORTCUT_EN
    last   = (cnt == 3'd7) || (d == 4'd0);
`else
    last   = (cnt == 3'd7);
`endif
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = RUN;
      RUN:     if (last) state_n = DONE;
      DONE:    state_n = start ? RUN : IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      d           <= 4'h0;
      a           <= 8'h00;
      r           <= 4'h0;
      cnt         <= 3'd0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= 8'h00;
      remainder   <= 4'h0;
      div_by_zero <= 1'b0;
    end else begin
      state <= state_n;
      busy  <= (state_n == RUN);
      done  <= (state_n == DONE);
      if (state != RUN) begin
        if (start) begin
          d           <= divisor;
          a           <= dividend;
          r           <= 4'h0;
          cnt         <= 3'd0;
          div_by_zero <= 1'b0;
        end
      end else begin
        a   <= a_step;
        r   <= r_step;
        cnt <= cnt + 3'd1;
        if (last) begin
          if (d == 4'd0) begin
            quotient    <= 8'hFF;
            remainder   <= 4'h0;
            div_by_zero <= 1'b1;
          end else begin
            quotient    <= a_step;
            remainder   <= r_step;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_restoring_divider_8x4.sv
// tb/tb_restoring_divider_8x4.sv - random and directed bench for restoring_divider_8x4 with a behavioural model
module tb_restoring_divider_8x4;

`ifdef DIVIDER_ZERO_SHORTCUT_EN
  localparam int ZLAT = 1;
`else
  localparam int ZLAT = 8;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [7:0] dividend = 8'h00;
  logic [3:0] divisor = 4'h0;
  logic       busy, done, div_by_zero;
  logic [7:0] quotient;
  logic [3:0] remainder;

  restoring_divider_8x4 dut (
    .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int fails = 0;
  bit chk_en = 1'b0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Behavioural model: a countdown to completion and results from plain / and %.
  logic       m_busy = 0, m_done = 0, m_z = 0;
  logic [7:0] m_q = 0, p_q = 0;
  logic [3:0] m_r = 0, p_r = 0;
  logic       p_z = 0;
  int         m_left = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 0; m_done = 0; m_q = 0; m_r = 0; m_z = 0; m_left = 0;
    end else begin
      m_done = 0;
      if (m_left != 0) begin
        m_left--;
        if (m_left == 0) begin
          m_done = 1; m_busy = 0; m_q = p_q; m_r = p_r; m_z = p_z;
        end
      end else if (start) begin
        if (divisor == 0) begin
          p_q = 8'hFF; p_r = 4'h0; p_z = 1; m_left = ZLAT;
        end else begin
          p_q = 8'(dividend / divisor); p_r = 4'(dividend % divisor); p_z = 0; m_left = 8;
        end
        m_busy = 1; m_z = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en)
      chk("outputs{busy,done,q,r,dbz}", 32'({busy, done, quotient, remainder, div_by_zero}),
          32'({m_busy, m_done, m_q, m_r, m_z}));
  end

  task automatic run_op(input logic [7:0] x, input logic [3:0] y, input int exp_lat,
                        input bit lit, input logic [7:0] eq, input logic [3:0] er, input logic ez,
                        input string name);
    int lat;
    @(posedge clk); #2;
    dividend = x; divisor = y; start = 1;
    @(posedge clk); #2;
    start = 0; dividend = 8'($urandom); divisor = 4'($urandom);
    lat = 0;
    while (lat < 20) begin
      @(negedge clk);
      if (done) break;
      lat++;
    end
    chk({name, " latency"}, 32'(lat), 32'(exp_lat));
    if (lit) begin
      chk({name, " quotient"}, 32'(quotient), 32'(eq));
      chk({name, " remainder"}, 32'(remainder), 32'(er));
      chk({name, " div_by_zero"}, 32'(div_by_zero), 32'(ez));
    end
    @(negedge clk);
    chk({name, " done pulse width"}, 32'(done), 32'd0);
  endtask

  initial begin
    int ndone;
    int dcyc[$];
    logic [7:0] cq;
    logic [3:0] cr;

    #3 rst = 1;
    chk_en = 1;
    @(negedge clk);
    chk("reset state", 32'({busy, done, quotient, remainder, div_by_zero}), 32'd0);
    @(posedge clk); #2 rst = 0;

    run_op(8'd200, 4'd7, 8, 1, 8'd28, 4'd4, 1'b0, "200/7");
    run_op(8'd225, 4'd15, 8, 1, 8'd15, 4'd0, 1'b0, "225/15");
    run_op(8'd255, 4'd15, 8, 1, 8'd17, 4'd0, 1'b0, "255/15");
    run_op(8'd9, 4'd10, 8, 1, 8'd0, 4'd9, 1'b0, "9/10");
    run_op(8'd0, 4'd5, 8, 1, 8'd0, 4'd0, 1'b0, "0/5");
    run_op(8'h5A, 4'd0, ZLAT, 1, 8'hFF, 4'd0, 1'b1, "5A/0");

    // Starts while busy are ignored.
    @(posedge clk); #2 dividend = 8'd100; divisor = 4'd3; start = 1;
    @(posedge clk); #2 start = 0;
    repeat (2) @(posedge clk);
    #2 dividend = 8'd9; divisor = 4'd2; start = 1;
    @(posedge clk); #2 start = 0;
    @(posedge clk); #2 start = 1;
    @(posedge clk); #2 start = 0;
    ndone = 0; cq = 0; cr = 0;
    repeat (15) begin
      @(negedge clk);
      if (done) begin ndone++; cq = quotient; cr = remainder; end
    end
    chk("busy-start done count", 32'(ndone), 32'd1);
    chk("busy-start quotient", 32'(cq), 32'd33);
    chk("busy-start remainder", 32'(cr), 32'd1);

    // Reset mid-operation aborts with no done.
    @(posedge clk); #2 dividend = 8'd200; divisor = 4'd7; start = 1;
    @(posedge clk); #2 start = 0;
    repeat (3) @(posedge clk);
    #2 rst = 1;
    @(negedge clk);
    chk("mid-op reset outputs", 32'({busy, done, quotient, remainder, div_by_zero}), 32'd0);
    @(posedge clk); #2 rst = 0;
    ndone = 0;
    repeat (10) begin @(negedge clk); if (done) ndone++; end
    chk("aborted op done count", 32'(ndone), 32'd0);
    run_op(8'd50, 4'd6, 8, 1, 8'd8, 4'd2, 1'b0, "50/6");

    // Held start: one result every 9 cycles.
    @(posedge clk); #2 dividend = 8'd144; divisor = 4'd12; start = 1;
    repeat (40) begin
      @(negedge clk);
      if (done) begin
        dcyc.push_back(cyc);
        chk("held-start quotient", 32'(quotient), 32'd12);
        chk("held-start remainder", 32'(remainder), 32'd0);
      end
    end
    chk("held-start done count", 32'(dcyc.size()), 32'd4);
    for (int i = 1; i < dcyc.size(); i++)
      chk("held-start period", 32'(dcyc[i] - dcyc[i-1]), 32'd9);
    @(posedge clk); #2 start = 0;
    repeat (12) @(posedge clk);

    for (int x = 0; x < 256; x++)
      for (int y = 0; y < 16; y++)
        run_op(8'(x), 4'(y), (y == 0) ? ZLAT : 8, 0, 8'h00, 4'h0, 1'b0, "sweep");

    repeat (3000) begin
      @(posedge clk); #2;
      start = ($urandom_range(2) == 0);
      dividend = 8'($urandom);
      divisor = 4'($urandom);
      rst = ($urandom_range(255) == 0);
    end
    @(posedge clk); #2 rst = 0; start = 0;
    repeat (12) @(posedge clk);

    chk_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
